tick_scheduler: RTL and testbench

//  Shares one prescaled timebase among CHANNELS independent software timers.
//  An internal prescaler divides clk by DIVISOR into a 1-cycle tick. Each channel

---
 rtl/tick_sched_pkg.sv | 8 +
 rtl/tick_prescaler.sv | 16 +
 rtl/tick_scheduler.sv | 78 +++++++
 tb/tb_tick_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared command, mode and channel-state encodings for tick_scheduler
package tick_sched_pkg;
  localparam logic CMD_STOP = 1'b0;
  localparam logic CMD_START = 1'b1;
  localparam logic MODE_ONE_SHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by DIVISOR into a 1-cycle tick, parked at 0 while disabled
module tick_prescaler #(
  parameter int DIVISOR = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIVISOR);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || cnt == W'(DIVISOR - 1)) ? '0 : cnt + 1'b1;
  assign tick = en && cnt == W'(DIVISOR - 1);
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: CHANNELS software timers sharing one prescaled tick
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int DIVISOR = 50_000_000,
  parameter int CHANNELS = 4,
  parameter int CNT_W = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic                                          cfg_cmd,
  input  logic                                          cfg_mode,
  input  logic [CNT_W-1:0]                              cfg_period,
  output logic                                          tick,
  output logic [CHANNELS-1:0]                           busy,
  output logic [CHANNELS-1:0]                           expire
);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_ready <= 1'b0;
    else cfg_ready <= 1'b1;
  tick_prescaler #(.DIVISOR(DIVISOR)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (|busy),
    .tick (tick)
  );
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ch_state_t state, state_n;
    logic mode, mode_n, hit, exp_n;
    logic [CNT_W-1:0] period, period_n, rem, rem_n;
    assign hit = cfg_valid && cfg_ready && cfg_ch == CH_W'(c);
    // a config on this channel overrides a coincident tick
    always_comb begin
      state_n = state;
      mode_n = mode;
      period_n = period;
      rem_n = rem;
      exp_n = 1'b0;
      if (hit) begin
        if (cfg_cmd == CMD_START && cfg_period != '0) begin
          state_n = CH_RUN;
          mode_n = cfg_mode;
          period_n = cfg_period;
          rem_n = cfg_period;
        end else begin
          state_n = CH_IDLE;
          rem_n = '0;
        end
      end else if (state == CH_RUN && tick) begin
        if (rem > CNT_W'(1)) rem_n = rem - 1'b1;
        else begin
          exp_n = 1'b1;
          state_n = mode == MODE_PERIODIC ? CH_RUN : CH_IDLE;
          rem_n = mode == MODE_PERIODIC ? period : '0;
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= CH_IDLE;
        mode <= MODE_ONE_SHOT;
        period <= '0;
        rem <= '0;
        expire[c] <= 1'b0;
      end else begin
        state <= state_n;
        mode <= mode_n;
        period <= period_n;
        rem <= rem_n;
        expire[c] <= exp_n;
      end
    assign busy[c] = state == CH_RUN;
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed checks of tick_scheduler with DIVISOR=4, CHANNELS=4, CNT_W=8
module tb_tick_scheduler;
  import tick_sched_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_cmd = 1'b0, cfg_mode = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_period = '0;
  logic cfg_ready, tick;
  logic [3:0] busy, expire;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  tick_scheduler #(.DIVISOR(4), .CHANNELS(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_cmd   (cfg_cmd),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .tick      (tick),
    .busy      (busy),
    .expire    (expire)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] ch, input logic cmd, input logic mode, input logic [7:0] per);
    cfg_ch = ch;
    cfg_cmd = cmd;
    cfg_mode = mode;
    cfg_period = per;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    total++;
    if ({cfg_ready, busy, expire, tick} !== 10'b0)
      $display("FAIL reset_outputs: got %b want %b", {cfg_ready, busy, expire, tick}, 10'b0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if ({cfg_ready, busy} !== 5'b10000) $display("FAIL reset_release: got %b want 10000", {cfg_ready, busy});
    else passed++;
  endtask
  task automatic test_one_shot(input string tag);
    logic [8:0] want;
    issue(2'd0, CMD_START, MODE_ONE_SHOT, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      step();
      want = {(k < 12) ? 4'b0001 : 4'b0000, (k == 12) ? 4'b0001 : 4'b0000, (k == 3 || k == 7 || k == 11)};
      total++;
      if ({busy, expire, tick} !== want)
        $display("FAIL %s_k%0d busy/expire/tick: got %b want %b", tag, k, {busy, expire, tick}, want);
      else passed++;
    end
  endtask
  task automatic test_periodic;
    logic [7:0] want;
    issue(2'd1, CMD_START, MODE_PERIODIC, 8'd2);
    for (int k = 1; k <= 19; k++) begin
      step();
      want = {4'b0010, (k == 8 || k == 16) ? 4'b0010 : 4'b0000};
      total++;
      if ({busy, expire} !== want) $display("FAIL periodic_k%0d: got %b want %b", k, {busy, expire}, want);
      else passed++;
    end
    issue(2'd1, CMD_STOP, MODE_ONE_SHOT, 8'd0);
    for (int k = 20; k <= 26; k++) begin
      total++;
      if ({busy, expire, tick} !== 9'b0 || dut.u_pre.cnt !== 2'd0)
        $display("FAIL periodic_stop_k%0d: got %b cnt %0d want 0 cnt 0", k, {busy, expire, tick}, dut.u_pre.cnt);
      else passed++;
      step();
    end
  endtask
  task automatic test_dual;
    logic [3:0] want;
    issue(2'd0, CMD_START, MODE_PERIODIC, 8'd1);
    issue(2'd1, CMD_START, MODE_PERIODIC, 8'd2);
    for (int k = 2; k <= 9; k++) begin
      step();
      want = (k == 4) ? 4'b0001 : (k == 8) ? 4'b0011 : 4'b0000;
      total++;
      if (expire !== want) $display("FAIL dual_k%0d expire: got %b want %b", k, expire, want);
      else passed++;
    end
    issue(2'd0, CMD_STOP, MODE_ONE_SHOT, 8'd0);
    issue(2'd1, CMD_STOP, MODE_ONE_SHOT, 8'd0);
    step();
    total++;
    if ({busy, expire} !== 8'b0) $display("FAIL dual_stop: got %b want 0", {busy, expire});
    else passed++;
  endtask
  task automatic test_zero_stop;
    logic [3:0] want;
    issue(2'd0, CMD_START, MODE_PERIODIC, 8'd3);
    issue(2'd2, CMD_START, MODE_ONE_SHOT, 8'd0);
    total++;
    if (busy !== 4'b0001) $display("FAIL zero_period busy: got %b want 0001", busy);
    else passed++;
    issue(2'd3, CMD_STOP, MODE_ONE_SHOT, 8'd0);
    total++;
    if (busy !== 4'b0001) $display("FAIL stop_idle busy: got %b want 0001", busy);
    else passed++;
    for (int k = 3; k <= 14; k++) begin
      step();
      want = (k == 12) ? 4'b0001 : 4'b0000;
      total++;
      if (expire !== want) $display("FAIL zero_stop_k%0d expire: got %b want %b", k, expire, want);
      else passed++;
    end
    issue(2'd0, CMD_STOP, MODE_ONE_SHOT, 8'd0);
    total++;
    if (busy !== 4'b0000) $display("FAIL zero_stop_end busy: got %b want 0000", busy);
    else passed++;
    step();
  endtask
  task automatic test_restart;
    logic [7:0] want;
    issue(2'd0, CMD_START, MODE_ONE_SHOT, 8'd2);
    for (int k = 1; k <= 7; k++) step();
    total++;
    if (tick !== 1'b1) $display("FAIL restart_tick_before: got %b want 1", tick);
    else passed++;
    issue(2'd0, CMD_START, MODE_ONE_SHOT, 8'd5);
    total++;
    if ({busy, expire} !== 8'b00010000) $display("FAIL restart_edge: got %b want 00010000", {busy, expire});
    else passed++;
    for (int k = 9; k <= 30; k++) begin
      step();
      want = (k < 28) ? 8'b00010000 : (k == 28) ? 8'b00000001 : 8'b0;
      total++;
      if ({busy, expire} !== want) $display("FAIL restart_k%0d: got %b want %b", k, {busy, expire}, want);
      else passed++;
    end
  endtask
  task automatic test_async_reset;
    issue(2'd0, CMD_START, MODE_ONE_SHOT, 8'd1);
    for (int k = 1; k <= 4; k++) step();
    total++;
    if (expire !== 4'b0001) $display("FAIL async_pending: got %b want 0001", expire);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cfg_ready, busy, expire, tick} !== 10'b0)
      $display("FAIL async_clear: got %b want %b", {cfg_ready, busy, expire, tick}, 10'b0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if ({cfg_ready, busy} !== 5'b10000) $display("FAIL async_release: got %b want 10000", {cfg_ready, busy});
    else passed++;
    test_one_shot("post_reset");
  endtask
  initial begin
    test_reset();
    test_one_shot("oneshot");
    test_periodic();
    test_dual();
    test_zero_stop();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
